demux4_buf: RTL



---
 rtl/demux4_buf_pkg.sv | 15 +
 rtl/demux_fifo.sv | 75 +++++++
 rtl/demux4_buf.sv | 78 +++++++
 3 files changed

// File: rtl/demux4_buf_pkg.sv
// demux4_buf shared definitions:
// destination count, select width, destination names.
package demux4_buf_pkg;

    localparam int NUM_DEST = 4;
    localparam int SEL_W    = 2;

    typedef enum logic [SEL_W-1:0] {
        DEST0 = 2'd0,
        DEST1 = 2'd1,
        DEST2 = 2'd2,
        DEST3 = 2'd3
    } dest_e;

endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: per-destination first-word
// fall-through queue with occupancy count.
module demux_fifo
    import demux4_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     occ_o,
    output logic [WIDTH-1:0]           head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_push, do_pop;

    assign full_o  = (occ_q == OCC_W'(DEPTH));
    assign empty_o = (occ_q == '0);

    // A full queue never takes a word, even if it pops this cycle.
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    assign head_o = mem_q[rptr_q];
    assign occ_o  = occ_q;

    // Pointer and occupancy next state; flush clears everything.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            occ_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PTR_W'(1);
            if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // State registers; reset also zeroes storage so heads read 0.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            if (do_push) mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 stream demux with a small
// FIFO per destination so one stall blocks no other.
module demux4_buf
    import demux4_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SEL_W-1:0]                      in_sel,
    input  logic [WIDTH-1:0]                      in_data,
    output logic [NUM_DEST-1:0]                   out_valid,
    input  logic [NUM_DEST-1:0]                   out_ready,
    output logic [WIDTH-1:0]                      d0_out,
    output logic [WIDTH-1:0]                      d1_out,
    output logic [WIDTH-1:0]                      d2_out,
    output logic [WIDTH-1:0]                      d3_out,
    output logic [NUM_DEST*($clog2(DEPTH)+1)-1:0] occ
);

    localparam int OCC_W = $clog2(DEPTH) + 1;

    dest_e               sel;
    logic                sel_full;
    logic                accept;
    logic [NUM_DEST-1:0] full_w;
    logic [NUM_DEST-1:0] empty_w;
    logic [NUM_DEST-1:0] push_w;
    logic [WIDTH-1:0]    head_w [NUM_DEST];

    assign sel = dest_e'(in_sel);

    // Full flag of the selected destination; never looks at out_ready.
    always_comb begin
        sel_full = 1'b0;
        unique case (sel)
            DEST0: sel_full = full_w[0];
            DEST1: sel_full = full_w[1];
            DEST2: sel_full = full_w[2];
            DEST3: sel_full = full_w[3];
            default: sel_full = 1'b1;
        endcase
    end

    assign in_ready = ~sel_full & ~flush & rstn;
    assign accept   = in_valid & in_ready;

    for (genvar i = 0; i < NUM_DEST; i++) begin : g_dest
        assign push_w[i] = accept & (in_sel == SEL_W'(i));

        demux_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rstn    (rstn),
            .flush_i (flush),
            .push_i  (push_w[i]),
            .pop_i   (out_ready[i]),
            .data_i  (in_data),
            .full_o  (full_w[i]),
            .empty_o (empty_w[i]),
            .occ_o   (occ[i*OCC_W +: OCC_W]),
            .head_o  (head_w[i])
        );
    end

    assign out_valid = ~empty_w;
    assign d0_out    = head_w[0];
    assign d1_out    = head_w[1];
    assign d2_out    = head_w[2];
    assign d3_out    = head_w[3];

endmodule
